// File: rtl/tour_sequencer.sv
// Knight's-tour command sequencer: splits each move into vertical and horizontal legs
// and muxes them with UART commands into cmd_proc. Optional watchdog: SEQ_WATCHDOG_EN.
module tour_sequencer #(
   parameter int NUM_MOVES = 24,
   parameter int WD_CYCLES = 8000000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start_tour,
   input  logic [7:0]  move,
   output logic [4:0]  mv_indx,
   input  logic [15:0] cmd_UART,
   input  logic        cmd_rdy_UART,
   output logic        clr_cmd_rdy_UART,
   output logic [15:0] cmd,
   output logic        cmd_rdy,
   input  logic        clr_cmd_rdy,
   input  logic        send_resp,
   output logic [7:0]  resp,
   output logic        tour_err
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] VERT   = 3'd1;
   localparam logic [2:0] WAIT_V = 3'd2;
   localparam logic [2:0] HORZ   = 3'd3;
   localparam logic [2:0] WAIT_H = 3'd4;

   localparam logic [7:0] NORTH = 8'h00;
   localparam logic [7:0] WEST  = 8'h3F;
   localparam logic [7:0] SOUTH = 8'h7F;
   localparam logic [7:0] EAST  = 8'hBF;

   localparam logic [7:0] RESP_MORE = 8'hA5;
   localparam logic [7:0] RESP_DONE = 8'h5A;

   localparam logic [4:0] LAST = 5'(NUM_MOVES - 1);

   logic [2:0] state;
   logic [2:0] nxt;
   logic       last;
   logic       wd_hit;
   logic [7:0] hdg_v;
   logic [7:0] hdg_h;
   logic [3:0] sq_v;
   logic [3:0] sq_h;

   assign last = (mv_indx == LAST);

   // Lowest set bit wins; an all-zero move falls through to bit 0.
   always_comb begin
      hdg_v = NORTH;
      sq_v  = 4'd2;
      hdg_h = EAST;
      sq_h  = 4'd1;
      casez (move)
         8'b???????1, 8'b00000000: begin
            hdg_v = NORTH; sq_v = 4'd2;
            hdg_h = EAST;  sq_h = 4'd1;
         end
         8'b??????10: begin
            hdg_v = NORTH; sq_v = 4'd2;
            hdg_h = WEST;  sq_h = 4'd1;
         end
         8'b?????100: begin
            hdg_v = NORTH; sq_v = 4'd1;
            hdg_h = WEST;  sq_h = 4'd2;
         end
         8'b????1000: begin
            hdg_v = SOUTH; sq_v = 4'd1;
            hdg_h = WEST;  sq_h = 4'd2;
         end
         8'b???10000: begin
            hdg_v = SOUTH; sq_v = 4'd2;
            hdg_h = WEST;  sq_h = 4'd1;
         end
         8'b??100000: begin
            hdg_v = SOUTH; sq_v = 4'd2;
            hdg_h = EAST;  sq_h = 4'd1;
         end
         8'b?1000000: begin
            hdg_v = SOUTH; sq_v = 4'd1;
            hdg_h = EAST;  sq_h = 4'd2;
         end
         8'b10000000: begin
            hdg_v = NORTH; sq_v = 4'd1;
            hdg_h = EAST;  sq_h = 4'd2;
         end
         default: begin
            hdg_v = NORTH; sq_v = 4'd2;
            hdg_h = EAST;  sq_h = 4'd1;
         end
      endcase
   end

   always_comb begin
      nxt = state;
      unique case (state)
         IDLE:    if (start_tour)  nxt = VERT;
         VERT:    if (clr_cmd_rdy) nxt = WAIT_V;
         WAIT_V:  if (send_resp)   nxt = HORZ;
         HORZ:    if (clr_cmd_rdy) nxt = WAIT_H;
         WAIT_H:  if (send_resp)   nxt = last ? IDLE : VERT;
         default: nxt = IDLE;
      endcase
      if (wd_hit) nxt = IDLE;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         mv_indx <= 5'd0;
      end else begin
         state <= nxt;
         if (wd_hit)
            mv_indx <= 5'd0;
         else if (state == IDLE && start_tour)
            mv_indx <= 5'd0;
         else if (state == WAIT_H && send_resp && !last)
            mv_indx <= mv_indx + 5'd1;
      end
   end

`ifdef SEQ_WATCHDOG_EN
   localparam logic [22:0] WD_LAST = 23'(WD_CYCLES - 1);

   logic [22:0] wd_cnt;
   logic        waiting;
   logic        err_q;

   assign waiting  = (state == WAIT_V) || (state == WAIT_H);
   assign wd_hit   = waiting && !send_resp && (wd_cnt == WD_LAST);
   assign tour_err = err_q;

   // Counter restarts whenever the state changes so each leg gets a full budget.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wd_cnt <= 23'd0;
         err_q  <= 1'b0;
      end else begin
         err_q <= wd_hit;
         if (nxt != state)
            wd_cnt <= 23'd0;
         else if (waiting)
            wd_cnt <= wd_cnt + 23'd1;
         else
            wd_cnt <= 23'd0;
      end
   end
`else
   assign wd_hit   = 1'b0;
   assign tour_err = 1'b0;
`endif

   always_comb begin
      cmd              = cmd_UART;
      cmd_rdy          = 1'b0;
      clr_cmd_rdy_UART = 1'b0;
      resp             = RESP_MORE;
      unique case (state)
         IDLE: begin
            cmd              = cmd_UART;
            cmd_rdy          = cmd_rdy_UART;
            clr_cmd_rdy_UART = clr_cmd_rdy;
            resp             = RESP_DONE;
         end
         VERT: begin
            cmd     = {4'b0010, hdg_v, sq_v};
            cmd_rdy = 1'b1;
         end
         WAIT_V: begin
            cmd = {4'b0010, hdg_v, sq_v};
         end
         HORZ: begin
            cmd     = {4'b0011, hdg_h, sq_h};
            cmd_rdy = 1'b1;
         end
         WAIT_H: begin
            cmd  = {4'b0011, hdg_h, sq_h};
            resp = last ? RESP_DONE : RESP_MORE;
         end
         default: begin
            cmd     = cmd_UART;
            cmd_rdy = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_tour_sequencer.sv
// Directed self-checking bench for tour_sequencer (default build, watchdog off).
module tb_tour_sequencer;

   logic        clk;
   logic        rst_n;
   logic        start_tour;
   logic [7:0]  move;
   logic [4:0]  mv_indx;
   logic [15:0] cmd_UART;
   logic        cmd_rdy_UART;
   logic        clr_cmd_rdy_UART;
   logic [15:0] cmd;
   logic        cmd_rdy;
   logic        clr_cmd_rdy;
   logic        send_resp;
   logic [7:0]  resp;
   logic        tour_err;

   logic [7:0] mem [0:23];
   int         pass_cnt;
   int         total;
   int         uart_leak;
   bit         in_tour;

   tour_sequencer dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .start_tour       (start_tour),
      .move             (move),
      .mv_indx          (mv_indx),
      .cmd_UART         (cmd_UART),
      .cmd_rdy_UART     (cmd_rdy_UART),
      .clr_cmd_rdy_UART (clr_cmd_rdy_UART),
      .cmd              (cmd),
      .cmd_rdy          (cmd_rdy),
      .clr_cmd_rdy      (clr_cmd_rdy),
      .send_resp        (send_resp),
      .resp             (resp),
      .tour_err         (tour_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb move = (mv_indx < 5'd24) ? mem[mv_indx] : 8'h00;

   always @(posedge clk)
      if (in_tour && clr_cmd_rdy_UART === 1'b1) uart_leak++;

   // Reference leg from the knight delta table.
   function automatic logic [15:0] exp_leg(input logic [7:0] m, input bit horiz);
      int dxs [8] = '{1, -1, -2, -2, -1, 1, 2, 2};
      int dys [8] = '{2, 2, 1, -1, -2, -2, -1, 1};
      int b = 0;
      int d;
      logic [7:0] h;
      for (int k = 7; k >= 0; k--) if (m[k]) b = k;
      if (horiz) begin
         d = dxs[b];
         h = (d > 0) ? 8'hBF : 8'h3F;
         return {4'h3, h, 4'((d > 0) ? d : -d)};
      end
      d = dys[b];
      h = (d > 0) ? 8'h00 : 8'h7F;
      return {4'h2, h, 4'((d > 0) ? d : -d)};
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; start_tour = 0; clr_cmd_rdy = 0; send_resp = 0;
      cmd_rdy_UART = 0; cmd_UART = 16'h1234;
      tick(); tick();
      #1;
      total++;
      if (cmd_rdy !== 1'b0 || cmd !== 16'h1234) $display("FAIL reset_cmd: cmd=%h rdy=%b want 1234/0", cmd, cmd_rdy);
      else pass_cnt++;
      total++;
      if (resp !== 8'h5A || clr_cmd_rdy_UART !== 1'b0 || tour_err !== 1'b0)
         $display("FAIL reset_outs: resp=%h clr=%b err=%b want 5a/0/0", resp, clr_cmd_rdy_UART, tour_err);
      else pass_cnt++;
      total++;
      if (mv_indx !== 5'd0) $display("FAIL reset_idx: got %0d want 0", mv_indx);
      else pass_cnt++;
      rst_n = 1'b1;
   endtask

   task automatic test_uart_passthru;
      tick();
      cmd_rdy_UART = 1; cmd_UART = 16'h2002;
      #1;
      total++;
      if (cmd !== 16'h2002 || cmd_rdy !== 1'b1) $display("FAIL uart_fwd: cmd=%h rdy=%b want 2002/1", cmd, cmd_rdy);
      else pass_cnt++;
      clr_cmd_rdy = 1;
      #1;
      total++;
      if (clr_cmd_rdy_UART !== 1'b1) $display("FAIL uart_clr: got %b want 1", clr_cmd_rdy_UART);
      else pass_cnt++;
      total++;
      if (resp !== 8'h5A) $display("FAIL uart_resp: got %h want 5a", resp);
      else pass_cnt++;
      clr_cmd_rdy = 0; cmd_rdy_UART = 0;
      #1;
      total++;
      if (clr_cmd_rdy_UART !== 1'b0) $display("FAIL uart_clr_low: got %b want 0", clr_cmd_rdy_UART);
      else pass_cnt++;
   endtask

   task automatic test_legs;
      logic [7:0]  pm [7] = '{8'h01, 8'h08, 8'h40, 8'h02, 8'h80, 8'h0C, 8'h00};
      logic [15:0] pv [7] = '{16'h2002, 16'h27F1, 16'h27F1, 16'h2002, 16'h2001, 16'h2001, 16'h2002};
      logic [15:0] ph [7] = '{16'h3BF1, 16'h33F2, 16'h3BF2, 16'h33F1, 16'h3BF2, 16'h33F2, 16'h3BF1};
      for (int p = 0; p < 7; p++) begin
         do_reset();
         mem[0] = pm[p];
         start_tour = 1;
         tick();
         start_tour = 0;
         #1;
         total++;
         if (cmd !== pv[p] || cmd_rdy !== 1'b1)
            $display("FAIL leg_v[%0h]: cmd=%h rdy=%b want %h/1", pm[p], cmd, cmd_rdy, pv[p]);
         else pass_cnt++;
         clr_cmd_rdy = 1; tick(); clr_cmd_rdy = 0;
         send_resp = 1; tick(); send_resp = 0;
         #1;
         total++;
         if (cmd !== ph[p] || cmd_rdy !== 1'b1 || resp !== 8'hA5)
            $display("FAIL leg_h[%0h]: cmd=%h rdy=%b resp=%h want %h/1/a5", pm[p], cmd, cmd_rdy, resp, ph[p]);
         else pass_cnt++;
      end
      do_reset();
   endtask

   task automatic test_vert_corner;
      mem[0] = 8'h01; mem[1] = 8'h08;
      start_tour = 1; tick(); start_tour = 0;
      send_resp = 1; tick(); send_resp = 0;
      #1;
      total++;
      if (cmd_rdy !== 1'b1 || cmd !== 16'h2002) $display("FAIL vert_ignores_resp: cmd=%h rdy=%b want 2002/1", cmd, cmd_rdy);
      else pass_cnt++;
      clr_cmd_rdy = 1; send_resp = 1; tick(); clr_cmd_rdy = 0; send_resp = 0;
      start_tour = 1; tick(); start_tour = 0;
      #1;
      total++;
      if (cmd_rdy !== 1'b0 || resp !== 8'hA5) $display("FAIL resp_dropped: rdy=%b resp=%h want 0/a5", cmd_rdy, resp);
      else pass_cnt++;
      send_resp = 1; tick(); send_resp = 0;
      clr_cmd_rdy = 1; tick(); clr_cmd_rdy = 0;
      send_resp = 1; tick(); send_resp = 0;
      #1;
      total++;
      if (mv_indx !== 5'd1 || cmd !== 16'h27F1 || cmd_rdy !== 1'b1)
         $display("FAIL next_move: idx=%0d cmd=%h rdy=%b want 1/27f1/1", mv_indx, cmd, cmd_rdy);
      else pass_cnt++;
      do_reset();
   endtask

   task automatic test_full_tour;
      int hs;
      for (int i = 0; i < 24; i++) mem[i] = 8'h01 << (i % 8);
      mem[20] = 8'h30;
      do_reset();
      cmd_rdy_UART = 1; cmd_UART = 16'h5555;
      uart_leak = 0; in_tour = 1; hs = 0;
      start_tour = 1; tick(); start_tour = 0;
      #1;
      for (int i = 0; i < 24; i++) begin
         total++;
         if (cmd_rdy !== 1'b1 || mv_indx !== 5'(i) || cmd !== exp_leg(mem[i], 0))
            $display("FAIL tour_v[%0d]: idx=%0d cmd=%h rdy=%b want %h/1", i, mv_indx, cmd, cmd_rdy, exp_leg(mem[i], 0));
         else pass_cnt++;
         if (cmd_rdy === 1'b1) hs++;
         clr_cmd_rdy = 1; tick(); clr_cmd_rdy = 0;
         tick();
         send_resp = 1; tick(); send_resp = 0;
         #1;
         total++;
         if (cmd_rdy !== 1'b1 || cmd !== exp_leg(mem[i], 1))
            $display("FAIL tour_h[%0d]: cmd=%h rdy=%b want %h/1", i, cmd, cmd_rdy, exp_leg(mem[i], 1));
         else pass_cnt++;
         if (cmd_rdy === 1'b1) hs++;
         clr_cmd_rdy = 1; tick(); clr_cmd_rdy = 0;
         #1;
         total++;
         if (resp !== ((i == 23) ? 8'h5A : 8'hA5))
            $display("FAIL tour_resp[%0d]: got %h want %h", i, resp, (i == 23) ? 8'h5A : 8'hA5);
         else pass_cnt++;
         send_resp = 1; tick(); send_resp = 0;
         #1;
      end
      in_tour = 0;
      total++;
      if (hs !== 48) $display("FAIL tour_handshakes: got %0d want 48", hs);
      else pass_cnt++;
      total++;
      if (uart_leak !== 0) $display("FAIL tour_uart_blocked: leaks=%0d want 0", uart_leak);
      else pass_cnt++;
      total++;
      if (cmd_rdy !== 1'b1 || cmd !== 16'h5555 || resp !== 8'h5A)
         $display("FAIL tour_idle: cmd=%h rdy=%b resp=%h want 5555/1/5a", cmd, cmd_rdy, resp);
      else pass_cnt++;
      clr_cmd_rdy = 1;
      #1;
      total++;
      if (clr_cmd_rdy_UART !== 1'b1) $display("FAIL tour_uart_after: got %b want 1", clr_cmd_rdy_UART);
      else pass_cnt++;
      clr_cmd_rdy = 0; cmd_rdy_UART = 0;
   endtask

   task automatic test_reset_mid_tour;
      for (int i = 0; i < 24; i++) mem[i] = 8'h80;
      do_reset();
      start_tour = 1; tick(); start_tour = 0;
      for (int i = 0; i < 5; i++) begin
         clr_cmd_rdy = 1; tick(); clr_cmd_rdy = 0;
         send_resp = 1; tick(); send_resp = 0;
         clr_cmd_rdy = 1; tick(); clr_cmd_rdy = 0;
         send_resp = 1; tick(); send_resp = 0;
      end
      #1;
      total++;
      if (mv_indx !== 5'd5 || cmd_rdy !== 1'b1) $display("FAIL mid_idx: idx=%0d rdy=%b want 5/1", mv_indx, cmd_rdy);
      else pass_cnt++;
      rst_n = 0; tick(); rst_n = 1;
      #1;
      total++;
      if (mv_indx !== 5'd0 || cmd_rdy !== 1'b0 || resp !== 8'h5A)
         $display("FAIL mid_reset: idx=%0d rdy=%b resp=%h want 0/0/5a", mv_indx, cmd_rdy, resp);
      else pass_cnt++;
      tick(); tick(); tick();
      total++;
      if (cmd_rdy !== 1'b0 || tour_err !== 1'b0) $display("FAIL mid_quiet: rdy=%b err=%b want 0/0", cmd_rdy, tour_err);
      else pass_cnt++;
   endtask

   initial begin
      pass_cnt = 0; total = 0; uart_leak = 0; in_tour = 0;
      for (int i = 0; i < 24; i++) mem[i] = 8'h01;
      test_reset();
      test_uart_passthru();
      test_legs();
      test_vert_corner();
      test_full_tour();
      test_reset_mid_tour();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule

// File: doc/tour_sequencer.md
# tour_sequencer

Sequences a computed knight's tour into the motion command path. After the solver finishes, it walks the 24-entry move list and turns each knight move into two single-axis commands: a vertical leg, then a horizontal leg. It shares the single command-processor input between the UART command path and its own tour commands. It sits between the UART wrapper, the tour solver memory and cmd_proc.

## Interface
Parameters:
- NUM_MOVES, 24: number of knight moves in a tour; mv_indx wraps to IDLE after the last one.
- WD_CYCLES, 8000000: watchdog limit in clocks per leg. Used only with SEQ_WATCHDOG_EN.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock; reset is synchronous and active-low
- start_tour  in  1  pulse from solver: move list ready
- move  in  8  one-hot move read at mv_indx
- mv_indx  out  5  move-list read index
- cmd_UART  in  16  command from UART wrapper
- cmd_rdy_UART  in  1  UART command valid
- clr_cmd_rdy_UART  out  1  consume pulse back to UART wrapper
- cmd  out  16  command to cmd_proc
- cmd_rdy  out  1  command valid to cmd_proc
- clr_cmd_rdy  in  1  cmd_proc has latched cmd
- send_resp  in  1  cmd_proc pulse: leg complete
- resp  out  8  response byte: 0xA5 = tour leg done, more follow; 0x5A = ack / tour complete
- tour_err  out  1  one-cycle watchdog abort pulse (0 when SEQ_WATCHDOG_EN is undefined)

## Operation
- States: IDLE, VERT, WAIT_V, HORZ, WAIT_H.
- **IDLE (UART mode)**
  - cmd = cmd_UART, cmd_rdy = cmd_rdy_UART.
  - clr_cmd_rdy_UART = clr_cmd_rdy.
  - resp = 0x5A.
  - start_tour: mv_indx←0, go to VERT.
- **VERT**
  - cmd_rdy=1, cmd = {4'b0010, hdg_v, sq_v}.
  - On clr_cmd_rdy, go to WAIT_V.
  - send_resp is ignored in this state.
- **WAIT_V**
  - cmd_rdy=0.
  - On send_resp, go to HORZ.
- **HORZ**
  - cmd_rdy=1, cmd = {4'b0011, hdg_h, sq_h}. Opcode 0011 is move with fanfare.
  - On clr_cmd_rdy, go to WAIT_H.
- **WAIT_H**
  - On send_resp: if mv_indx==NUM_MOVES-1, go to IDLE. Otherwise mv_indx+1 and go to VERT.
- In every tour state:
  - cmd_rdy_UART is ignored and clr_cmd_rdy_UART=0. A pending UART command stays pending until IDLE.
  - resp = 0xA5, except in WAIT_H at mv_indx==NUM_MOVES-1, where resp = 0x5A.
- Headings (cmd[11:4]): north 0x00, west 0x3F, south 0x7F, east 0xBF.
- Move decode (bit: dx,dy):
  - 0: +1,+2
  - 1: −1,+2
  - 2: −2,+1
  - 3: −2,−1
  - 4: −1,−2
  - 5: +1,−2
  - 6: +2,−1
  - 7: +2,+1
- Leg encoding:
  - Vertical leg: north if dy>0, else south; sq_v=|dy|.
  - Horizontal leg: east if dx>0, else west; sq_h=|dx|.
- Non-one-hot move: the lowest set bit wins. 8'h00 decodes as bit 0.
- start_tour outside IDLE is ignored.

## Timing
- Reset values:
  - state IDLE, mv_indx 0, cmd_rdy = cmd_rdy_UART (0 when the UART is quiet), cmd = cmd_UART.
  - resp 0x5A, clr_cmd_rdy_UART 0, tour_err 0.
- start_tour at edge N: VERT at N+1, cmd_rdy high in that same cycle. cmd/cmd_rdy are decoded combinationally from state, mv_indx and move.
- move must be valid one cycle after mv_indx changes. The memory is combinational-read; move is re-sampled every cycle of VERT/HORZ.
- cmd holds stable while cmd_rdy=1 until clr_cmd_rdy.
- clr_cmd_rdy and send_resp in the same cycle while in VERT: the state goes to WAIT_V, and the send_resp is dropped.
- Reset asserted mid-tour: IDLE on the next edge, mv_indx 0, no further commands.

## Configuration
- SEQ_WATCHDOG_EN defined:
  - A 23-bit counter clears on each state entry and counts in WAIT_V/WAIT_H.
  - When it reaches WD_CYCLES−1 without send_resp: go to IDLE, mv_indx←0, tour_err pulses for 1 cycle.
- SEQ_WATCHDOG_EN undefined:
  - No counter; the sequencer waits forever for send_resp.
  - tour_err is tied 0.

## Test plan
- Reset, then hold cmd_rdy_UART=1, cmd_UART=0x2002 → cmd=0x2002, cmd_rdy=1. A clr_cmd_rdy pulse appears on clr_cmd_rdy_UART. resp=0x5A.
- start_tour with move[0]=8'h01 → cycle+1: cmd=0x2002, cmd_rdy=1. After clr_cmd_rdy+send_resp: cmd=0x3BF1, resp=0xA5.
- Move 8'h08 → legs 0x27F1 then 0x33F2. Move 8'h40 → legs 0x27F1 then 0x3BF2.
- Full 24-move tour with send_resp after each clr: exactly 48 clr_cmd_rdy handshakes, mv_indx steps 0→23, final resp=0x5A, return to IDLE.
- cmd_rdy_UART=1 during the tour → clr_cmd_rdy_UART stays 0 until IDLE, then the UART cmd is forwarded. rst_n=0 at mv_indx=5 → IDLE, mv_indx=0.
- SEQ_WATCHDOG_EN with WD_CYCLES=100, no send_resp → tour_err is a 1-cycle pulse 100 clocks after entering WAIT_V, then IDLE.
